// File: rtl/score_display.sv
// Binary score to five active-low seven-segment digits via sequential double-dabble,
// with leading-zero blanking and a game-over flash.
module score_display #(
   parameter bit BLANK_ZEROS = 1'b1,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] score,
   input  logic        gameOver,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic        busy,
   output logic        updated
);

   localparam int         BW        = $clog2(BLINK_DIV) + 1;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   state_t           state, state_next;
   logic [15:0]      last_score;
   logic [15:0]      bin;
   logic [19:0]      bcd;
   logic [19:0]      bcd_adj;
   logic [4:0]       cnt;
   logic [4:0][3:0]  dig;
   logic [BW-1:0]    blink_cnt;
   logic             blink_off;
   logic [4:0][6:0]  seg;
   logic             flash_off;
   logic             lz1, lz2, lz3, lz4;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (score != last_score) state_next = CONVERT;
         CONVERT: if (cnt == 5'd15)        state_next = LOAD;
         LOAD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign updated = (state == LOAD);

   // Add-3 correction on every nibble before it is shifted.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: the digit registers are few and observable at the pins, so they are reset like any other state.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_score <= '0;
         bin        <= '0;
         bcd        <= '0;
         cnt        <= '0;
         dig        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (score != last_score) begin
                  bin        <= score;
                  last_score <= score;
                  bcd        <= '0;
                  cnt        <= '0;
               end
            end
            CONVERT: begin
               {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
               cnt        <= cnt + 5'd1;
            end
            LOAD: begin
               dig <= bcd;
            end
            default: ;
         endcase
      end
   end

   // Flash timer only runs while the game is over; otherwise it sits in the "on" phase.
   always_ff @(posedge clk) begin
      if (reset || !gameOver) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign flash_off = gameOver & blink_off;

   always_comb begin
      seg = '0;
      for (int k = 0; k < 5; k++) seg[k] = seg7(dig[k]);
   end

   assign lz4 = (dig[4] == 4'd0);
   assign lz3 = lz4 & (dig[3] == 4'd0);
   assign lz2 = lz3 & (dig[2] == 4'd0);
   assign lz1 = lz2 & (dig[1] == 4'd0);

   assign HEX0 = flash_off                        ? SEG_BLANK : seg[0];
   assign HEX1 = (flash_off || (BLANK_ZEROS && lz1)) ? SEG_BLANK : seg[1];
   assign HEX2 = (flash_off || (BLANK_ZEROS && lz2)) ? SEG_BLANK : seg[2];
   assign HEX3 = (flash_off || (BLANK_ZEROS && lz3)) ? SEG_BLANK : seg[3];
   assign HEX4 = (flash_off || (BLANK_ZEROS && lz4)) ? SEG_BLANK : seg[4];

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios plus random score/gameOver/reset
// traffic, compared every cycle against a cycle-count model of the displayed number.
module tb_score_display;

   localparam int BDIV = 4;

   logic        clk;
   logic        reset;
   logic [15:0] score;
   logic        gameOver;

   logic [6:0]  h0_a, h1_a, h2_a, h3_a, h4_a;
   logic [6:0]  h0_b, h1_b, h2_b, h3_b, h4_b;
   logic        busy_a, busy_b, upd_a, upd_b;
   logic [6:0]  hx [2][5];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the number shown, the one in flight and cycles left until it lands.
   int m_timer;
   int m_last;
   int m_conv;
   int m_disp;
   int m_go_n;

   score_display #(.BLANK_ZEROS(1'b1), .BLINK_DIV(BDIV)) dut_a (
      .clk(clk), .reset(reset), .score(score), .gameOver(gameOver),
      .HEX0(h0_a), .HEX1(h1_a), .HEX2(h2_a), .HEX3(h3_a), .HEX4(h4_a),
      .busy(busy_a), .updated(upd_a)
   );

   score_display #(.BLANK_ZEROS(1'b0), .BLINK_DIV(BDIV)) dut_b (
      .clk(clk), .reset(reset), .score(score), .gameOver(gameOver),
      .HEX0(h0_b), .HEX1(h1_b), .HEX2(h2_b), .HEX3(h3_b), .HEX4(h4_b),
      .busy(busy_b), .updated(upd_b)
   );

   assign hx[0][0] = h0_a; assign hx[0][1] = h1_a; assign hx[0][2] = h2_a;
   assign hx[0][3] = h3_a; assign hx[0][4] = h4_a;
   assign hx[1][0] = h0_b; assign hx[1][1] = h1_b; assign hx[1][2] = h2_b;
   assign hx[1][3] = h3_b; assign hx[1][4] = h4_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p *= 10;
      return p;
   endfunction

   function automatic logic [6:0] exp_hex(input int k, input bit blank_zeros);
      if (gameOver && ((m_go_n / BDIV) % 2 == 1)) return 7'b1111111;
      if (blank_zeros && k > 0 && m_disp < pow10(k)) return 7'b1111111;
      return seg_of((m_disp / pow10(k)) % 10);
   endfunction

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic model_update();
      if (reset) begin
         m_timer = 0;
         m_last  = 0;
         m_disp  = 0;
         m_go_n  = 0;
      end else begin
         if (m_timer == 0) begin
            if (int'(score) != m_last) begin
               m_last  = int'(score);
               m_conv  = int'(score);
               m_timer = 17;
            end
         end else begin
            m_timer--;
            if (m_timer == 0) m_disp = m_conv;
         end
         m_go_n = gameOver ? m_go_n + 1 : 0;
      end
   endtask

   task automatic check_outputs();
      check("busy_a", 32'(busy_a), 32'(m_timer != 0));
      check("busy_b", 32'(busy_b), 32'(m_timer != 0));
      check("updated_a", 32'(upd_a), 32'(m_timer == 1));
      check("updated_b", 32'(upd_b), 32'(m_timer == 1));
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_HEX%0d(disp=%0d)", (u == 0) ? "blank" : "noblank", k, m_disp),
                  32'(hx[u][k]), 32'(exp_hex(k, (u == 0))));
         end
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   initial begin
      m_timer  = 0;
      m_last   = 0;
      m_conv   = 0;
      m_disp   = 0;
      m_go_n   = 0;
      reset    = 1'b1;
      score    = 16'd0;
      gameOver = 1'b0;
      run(3);
      reset = 1'b0;
      run(20);

      score = 16'd123;   run(22);
      score = 16'd65535; run(22);
      score = 16'd1000;  run(22);

      // Change arrives mid-conversion; a second conversion must follow on its own.
      score = 16'd10;    run(3);
      score = 16'd11;    run(45);

      score = 16'd7;     run(22);
      gameOver = 1'b1;   run(21);
      gameOver = 1'b0;   run(3);
      gameOver = 1'b1;   run(6);
      gameOver = 1'b0;   run(3);

      // Reset lands in the middle of a conversion.
      score = 16'd999;   run(8);
      reset = 1'b1;      run(1);
      reset = 1'b0;      run(22);

      score = 16'd0;     run(22);

      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 7) == 0)
            score = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) gameOver = ~gameOver;
         reset = ($urandom_range(0, 299) == 0);
         step_cycle();
      end
      reset = 1'b0;
      gameOver = 1'b0;
      run(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
